// File: rtl/layer1_weight_update_seq.sv
// ============================================================================
//  Module      : layer1_weight_update_seq
//  Description : Layer-1 weight file plus a sequencer that feeds one weight at
//                a time through backprop_step2 and writes back its w_new.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module layer1_weight_update_seq #(
    parameter  int N_IN  = 2,
    parameter  int N_HID = 2,
    parameter  int LAT   = 8,
    localparam int NW    = N_IN * N_HID,
    localparam int AW    = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [31:0]           target,
    input  logic [31:0]           sigmoid_out,
    input  logic [31:0]           out_value,
    input  logic [N_HID*32-1:0]   l2_w,
    input  logic [N_HID*32-1:0]   hid_sig,
    input  logic [N_HID*32-1:0]   hid_val,
    input  logic [N_IN*32-1:0]    x_in,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           bp_target,
    output logic [31:0]           bp_sigmoid_out,
    output logic [31:0]           bp_out_value,
    output logic [31:0]           bp_layer2_weight,
    output logic [31:0]           bp_hidden_sigmoid,
    output logic [31:0]           bp_hidden_value,
    output logic [31:0]           bp_input,
    output logic [31:0]           bp_weight,
    input  logic [31:0]           bp_w_new,
    output logic [NW*32-1:0]      w_flat,
    output logic                  busy,
    output logic                  upd_valid,
    output logic [AW-1:0]         upd_addr,
    output logic                  done
);

    localparam int JW = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int CW = $clog2(LAT + 1);
    localparam logic [AW-1:0] K_LAST = AW'(NW - 1);
    localparam logic [CW-1:0] C_LAT  = CW'(LAT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           k_q, k_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NW-1:0][31:0]     w_q, w_d;

    logic [31:0]             tgt_snap_q, tgt_snap_d;
    logic [31:0]             so_snap_q, so_snap_d;
    logic [31:0]             ov_snap_q, ov_snap_d;
    logic [N_HID-1:0][31:0]  l2_snap_q, l2_snap_d;
    logic [N_HID-1:0][31:0]  hs_snap_q, hs_snap_d;
    logic [N_HID-1:0][31:0]  hv_snap_q, hv_snap_d;
    logic [N_IN-1:0][31:0]   x_snap_q, x_snap_d;

    logic [31:0]             bp_target_q, bp_target_d;
    logic [31:0]             bp_so_q, bp_so_d;
    logic [31:0]             bp_ov_q, bp_ov_d;
    logic [31:0]             bp_l2_q, bp_l2_d;
    logic [31:0]             bp_hs_q, bp_hs_d;
    logic [31:0]             bp_hv_q, bp_hv_d;
    logic [31:0]             bp_in_q, bp_in_d;
    logic [31:0]             bp_w_q, bp_w_d;

    logic                    busy_q, busy_d;
    logic                    upd_valid_q, upd_valid_d;
    logic [AW-1:0]           upd_addr_q, upd_addr_d;
    logic                    done_q, done_d;

    logic                    ld_bp;
    logic [JW-1:0]           w_j;
    logic [IW-1:0]           w_i;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        w_d         = w_q;
        tgt_snap_d  = tgt_snap_q;
        so_snap_d   = so_snap_q;
        ov_snap_d   = ov_snap_q;
        l2_snap_d   = l2_snap_q;
        hs_snap_d   = hs_snap_q;
        hv_snap_d   = hv_snap_q;
        x_snap_d    = x_snap_q;
        busy_d      = busy_q;
        upd_valid_d = 1'b0;
        upd_addr_d  = upd_addr_q;
        done_d      = 1'b0;
        ld_bp       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A load on the start edge lands first so the pass sees it.
                if (wr_en && (int'(wr_addr) < NW)) begin
                    w_d[wr_addr] = wr_data;
                end
                if (start) begin
                    tgt_snap_d = target;
                    so_snap_d  = sigmoid_out;
                    ov_snap_d  = out_value;
                    l2_snap_d  = l2_w;
                    hs_snap_d  = hid_sig;
                    hv_snap_d  = hid_val;
                    x_snap_d   = x_in;
                    k_d        = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    ld_bp      = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == C_LAT) begin
                    w_d[k_q]    = bp_w_new;
                    upd_valid_d = 1'b1;
                    upd_addr_d  = k_q;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + AW'(1);
                    cnt_d   = '0;
                    ld_bp   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand mux for the weight being issued: k = j*N_IN + i.
    always_comb begin
        w_j         = JW'(int'(k_d) / N_IN);
        w_i         = IW'(int'(k_d) % N_IN);
        bp_target_d = bp_target_q;
        bp_so_d     = bp_so_q;
        bp_ov_d     = bp_ov_q;
        bp_l2_d     = bp_l2_q;
        bp_hs_d     = bp_hs_q;
        bp_hv_d     = bp_hv_q;
        bp_in_d     = bp_in_q;
        bp_w_d      = bp_w_q;
        if (ld_bp) begin
            bp_target_d = tgt_snap_d;
            bp_so_d     = so_snap_d;
            bp_ov_d     = ov_snap_d;
            bp_l2_d     = l2_snap_d[w_j];
            bp_hs_d     = hs_snap_d[w_j];
            bp_hv_d     = hv_snap_d[w_j];
            bp_in_d     = x_snap_d[w_i];
            bp_w_d      = w_d[k_d];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            w_q         <= '0;
            tgt_snap_q  <= '0;
            so_snap_q   <= '0;
            ov_snap_q   <= '0;
            l2_snap_q   <= '0;
            hs_snap_q   <= '0;
            hv_snap_q   <= '0;
            x_snap_q    <= '0;
            bp_target_q <= '0;
            bp_so_q     <= '0;
            bp_ov_q     <= '0;
            bp_l2_q     <= '0;
            bp_hs_q     <= '0;
            bp_hv_q     <= '0;
            bp_in_q     <= '0;
            bp_w_q      <= '0;
            busy_q      <= 1'b0;
            upd_valid_q <= 1'b0;
            upd_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            w_q         <= w_d;
            tgt_snap_q  <= tgt_snap_d;
            so_snap_q   <= so_snap_d;
            ov_snap_q   <= ov_snap_d;
            l2_snap_q   <= l2_snap_d;
            hs_snap_q   <= hs_snap_d;
            hv_snap_q   <= hv_snap_d;
            x_snap_q    <= x_snap_d;
            bp_target_q <= bp_target_d;
            bp_so_q     <= bp_so_d;
            bp_ov_q     <= bp_ov_d;
            bp_l2_q     <= bp_l2_d;
            bp_hs_q     <= bp_hs_d;
            bp_hv_q     <= bp_hv_d;
            bp_in_q     <= bp_in_d;
            bp_w_q      <= bp_w_d;
            busy_q      <= busy_d;
            upd_valid_q <= upd_valid_d;
            upd_addr_q  <= upd_addr_d;
            done_q      <= done_d;
        end
    end

    assign bp_target         = bp_target_q;
    assign bp_sigmoid_out    = bp_so_q;
    assign bp_out_value      = bp_ov_q;
    assign bp_layer2_weight  = bp_l2_q;
    assign bp_hidden_sigmoid = bp_hs_q;
    assign bp_hidden_value   = bp_hv_q;
    assign bp_input          = bp_in_q;
    assign bp_weight         = bp_w_q;
    assign w_flat            = w_q;
    assign busy              = busy_q;
    assign upd_valid         = upd_valid_q;
    assign upd_addr          = upd_addr_q;
    assign done              = done_q;

endmodule

`default_nettype wire

// File: tb/tb_layer1_weight_update_seq.sv
// Directed bench for layer1_weight_update_seq with a latency-aware stand-in for backprop_step2.
`default_nettype none

module tb_layer1_weight_update_seq;

    localparam int N_IN  = 2;
    localparam int N_HID = 2;
    localparam int LAT   = 8;
    localparam int NW    = N_IN * N_HID;
    localparam int AW    = 2;
    localparam int PASS_EDGES = NW * (LAT + 2) + 1;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 start;
    logic [31:0]          target, sigmoid_out, out_value;
    logic [N_HID*32-1:0]  l2_w, hid_sig, hid_val;
    logic [N_IN*32-1:0]   x_in;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [31:0]          wr_data;
    logic [31:0]          bp_target, bp_sigmoid_out, bp_out_value, bp_layer2_weight;
    logic [31:0]          bp_hidden_sigmoid, bp_hidden_value, bp_input, bp_weight;
    logic [31:0]          bp_w_new;
    logic [NW*32-1:0]     w_flat;
    logic                 busy, upd_valid, done;
    logic [AW-1:0]        upd_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    layer1_weight_update_seq #(.N_IN(N_IN), .N_HID(N_HID), .LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .target(target), .sigmoid_out(sigmoid_out), .out_value(out_value),
        .l2_w(l2_w), .hid_sig(hid_sig), .hid_val(hid_val), .x_in(x_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .bp_target(bp_target), .bp_sigmoid_out(bp_sigmoid_out),
        .bp_out_value(bp_out_value), .bp_layer2_weight(bp_layer2_weight),
        .bp_hidden_sigmoid(bp_hidden_sigmoid), .bp_hidden_value(bp_hidden_value),
        .bp_input(bp_input), .bp_weight(bp_weight), .bp_w_new(bp_w_new),
        .w_flat(w_flat), .busy(busy), .upd_valid(upd_valid),
        .upd_addr(upd_addr), .done(done)
    );

    // Stand-in datapath: result is only meaningful after the operands have
    // been stable for LAT edges; before that it returns junk.
    logic [255:0] ops, ops_prev;
    int           age;
    assign ops = {bp_target, bp_sigmoid_out, bp_out_value, bp_layer2_weight,
                  bp_hidden_sigmoid, bp_hidden_value, bp_input, bp_weight};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ops_prev <= '0;
            age      <= 0;
        end else begin
            ops_prev <= ops;
            if (ops != ops_prev) age <= 0;
            else if (age < 1000) age <= age + 1;
        end
    end

    function automatic logic [31:0] model_w_new(input logic [31:0] w);
        if (bp_sigmoid_out != 32'h3F000000 || bp_hidden_sigmoid != 32'h3F000000 ||
            bp_layer2_weight != 32'h3F800000 || bp_out_value != 32'h3F400000 ||
            bp_hidden_value != 32'h3F000000)
            return 32'hBAD00000;
        if (bp_input == 32'h0 || bp_target != 32'h3F800000)
            return w;
        case (w)
            32'h3F800000: return 32'h3F820000;
            32'h3F820000: return 32'h3F840000;
            32'h40000000: return 32'h40010000;
            default:      return w ^ 32'h1;
        endcase
    endfunction

    always_comb begin
        bp_w_new = 32'hDEADBEEF;
        if (age >= LAT - 1) bp_w_new = model_w_new(bp_weight);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    task automatic load_w(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_all_ones();
        for (int k = 0; k < NW; k++) load_w(AW'(k), 32'h3F800000);
    endtask

    task automatic set_inputs(input logic [31:0] x0);
        target      = 32'h3F800000;
        sigmoid_out = 32'h3F000000;
        out_value   = 32'h3F400000;
        l2_w        = {2{32'h3F800000}};
        hid_sig     = {2{32'h3F000000}};
        hid_val     = {2{32'h3F000000}};
        x_in        = {32'h3F800000, x0};
    endtask

    // Runs one pass; checks upd address order, pulse count and done latency.
    task automatic run_pass(input bit wr_same, input logic [31:0] wr_d,
                            input bit chg, input bit junk);
        int n, nupd;
        @(negedge clk);
        start = 1'b1;
        if (wr_same) begin
            wr_en = 1'b1; wr_addr = '0; wr_data = wr_d;
        end
        @(posedge clk);
        #1;
        start = 1'b0; wr_en = 1'b0;
        if (chg) begin
            x_in   = '0;
            target = 32'h40400000;
        end
        n = 0; nupd = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (start) start = 1'b0;
            if (wr_en) wr_en = 1'b0;
            if (n == 1) chk("busy_run", 32'(busy), 32'd1);
            if (upd_valid) begin
                chk("upd_addr", 32'(upd_addr), 32'(nupd));
                nupd++;
            end
            if (junk && n == 15) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 32'h12345678;
            end
            if (done) break;
        end
        chk("done_lat", 32'(n), 32'(PASS_EDGES));
        chk("upd_cnt", 32'(nupd), 32'(NW));
        chk("busy_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("done_drop", 32'(done), 32'd0);
    endtask

    task automatic check_w(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
        chk({tag, "_w0"}, w_flat[31:0],   e0);
        chk({tag, "_w1"}, w_flat[63:32],  e1);
        chk({tag, "_w2"}, w_flat[95:64],  e2);
        chk({tag, "_w3"}, w_flat[127:96], e3);
    endtask

    initial begin
        int dn;
        reset_n = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        set_inputs(32'h3F800000);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bpw",  bp_weight, 32'd0);
        check_w("rst", 32'h0, 32'h0, 32'h0, 32'h0);
        reset_n = 1'b1;

        // Reset in the middle of a pass
        load_all_ones();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (11) @(negedge clk);
        chk("mid_w0_upd", w_flat[31:0], 32'h3F820000);
        chk("mid_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_w("arst", 32'h0, 32'h0, 32'h0, 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_upd",  32'(upd_valid), 32'd0);
        chk("arst_bpt",  bp_target, 32'd0);
        chk("arst_bpw",  bp_weight, 32'd0);
        dn = 0;
        repeat (3) begin @(negedge clk); if (done) dn++; end
        reset_n = 1'b1;
        repeat (5) begin @(negedge clk); if (done || busy) dn++; end
        chk("arst_nodone", 32'(dn), 32'd0);

        // Basic pass
        load_all_ones();
        check_w("load", 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        run_pass(1'b0, 32'h0, 1'b0, 1'b0);
        check_w("p2", 32'h3F820000, 32'h3F820000, 32'h3F820000, 32'h3F820000);

        // x_in[0] = 0: weights fed by input 0 stay put
        load_all_ones();
        set_inputs(32'h0);
        run_pass(1'b0, 32'h0, 1'b0, 1'b0);
        check_w("p3", 32'h3F800000, 32'h3F820000, 32'h3F800000, 32'h3F820000);

        // Inputs change right after start: snapshot must be used
        load_all_ones();
        set_inputs(32'h3F800000);
        run_pass(1'b0, 32'h0, 1'b1, 1'b0);
        check_w("p4", 32'h3F820000, 32'h3F820000, 32'h3F820000, 32'h3F820000);

        // start and wr_en while busy are ignored; second pass builds on the first
        load_all_ones();
        set_inputs(32'h3F800000);
        run_pass(1'b0, 32'h0, 1'b0, 1'b1);
        check_w("p5a", 32'h3F820000, 32'h3F820000, 32'h3F820000, 32'h3F820000);
        run_pass(1'b0, 32'h0, 1'b0, 1'b0);
        check_w("p5b", 32'h3F840000, 32'h3F840000, 32'h3F840000, 32'h3F840000);

        // Load on the start edge is committed before the pass reads it
        load_all_ones();
        run_pass(1'b1, 32'h40000000, 1'b0, 1'b0);
        check_w("p6", 32'h40010000, 32'h3F820000, 32'h3F820000, 32'h3F820000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
